alu_cmd_sequencer: RTL and testbench

- Command-side initiator for the structural ALU units (arithmetic, logic, compare, shift).
- Accepts one operation per valid/ready command handshake and drives the shared ALU operand, function and unit-enable buses.
- Waits for the selected unit's registered flag, captures its result, and returns it on a valid/ready response channel.
- Sits between the ALU top level and the controlling master; one operation in flight at a time.

---
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command-side initiator for the structural ALU units. Takes one operation
//   per cmd handshake, presents operands/function with a one-cycle unit enable
//   pulse, waits for the unit's registered flag (or times out), and returns the
//   captured result on the rsp channel. One operation in flight at a time.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | cmd_ready high, waiting for a command
//   ISSUE | one cycle, enable of the selected unit high
//   WAIT  | enables low, waiting for res_flag or wait_cnt terminal count
//   RESP  | rsp_valid high, holding rsp_data/rsp_err until rsp_ready
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op[3:0]              [3:2] unit select, [1:0] unit function
//   cmd_a, cmd_b             operands
//   alu_a, alu_b, alu_fun    shared operand/function bus to the units
//   *_enable                 one-hot unit enables (ISSUE only)
//   res_in, res_flag         OR-ed unit result and flag
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_err        captured result, timeout indication

module alu_cmd_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int WAIT_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [1:0]            alu_fun,
    output logic                  arith_enable,
    output logic                  logic_enable,
    output logic                  cmp_enable,
    output logic                  shift_enable,
    input  logic [DATA_WIDTH-1:0] res_in,
    input  logic                  res_flag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    // wait_cnt counts completed WAIT cycles; the timeout fires on the edge
    // that would make it reach WAIT_LIMIT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  wait_done;

    assign wait_done = (wait_cnt == CNT_LAST);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (res_flag || wait_done) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // command capture, wait counter and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wait_cnt <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                op_q <= cmd_op;
                a_q  <= cmd_a;
                b_q  <= cmd_b;
            end

            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !res_flag && !wait_done) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            // A flag wins over a simultaneous terminal count: a late result
            // is still a real result.
            if (state == S_WAIT) begin
                if (res_flag) begin
                    rsp_data <= res_in;
                    rsp_err  <= 1'b0;
                end else if (wait_done) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

    // outputs: decoded from state and registers only
    always_comb begin
        cmd_ready    = (state == S_IDLE);
        rsp_valid    = (state == S_RESP);
        alu_a        = a_q;
        alu_b        = b_q;
        alu_fun      = op_q[1:0];
        arith_enable = 1'b0;
        logic_enable = 1'b0;
        cmp_enable   = 1'b0;
        shift_enable = 1'b0;
        if (state == S_ISSUE) begin
            case (op_q[3:2])
                2'b00:   arith_enable = 1'b1;
                2'b01:   logic_enable = 1'b1;
                2'b10:   cmp_enable   = 1'b1;
                default: shift_enable = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_fun;
    logic        arith_enable;
    logic        logic_enable;
    logic        cmp_enable;
    logic        shift_enable;
    logic [15:0] res_in;
    logic        res_flag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    // unit model controls
    logic        unit_mute  = 1'b0;
    logic        force_flag = 1'b0;
    logic [15:0] unit_res   = '0;
    logic        unit_flag  = 1'b0;

    alu_cmd_sequencer #(.DATA_WIDTH(16), .WAIT_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_fun      (alu_fun),
        .arith_enable (arith_enable),
        .logic_enable (logic_enable),
        .cmp_enable   (cmp_enable),
        .shift_enable (shift_enable),
        .res_in       (res_in),
        .res_flag     (res_flag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] unit_eval(input logic [1:0] unit, input logic [1:0] fun,
                                              input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = '0;
        case (unit)
            2'd0: case (fun)
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd2: r = a + 16'd1;
                default: r = a - 16'd1;
            endcase
            2'd1: case (fun)
                2'd0: r = a & b;
                2'd1: r = a | b;
                2'd2: r = a ^ b;
                default: r = ~a;
            endcase
            2'd2: case (fun)
                2'd0: r = {15'd0, a == b};
                2'd1: r = {15'd0, a < b};
                2'd2: r = {15'd0, a > b};
                default: r = {15'd0, a != b};
            endcase
            default: case (fun)
                2'd0: r = a >> 1;
                2'd1: r = a << 1;
                2'd2: r = b >> 1;
                default: r = b << 1;
            endcase
        endcase
        return r;
    endfunction

    // registered ALU units: result and flag one edge after the enable
    always @(posedge clk) begin
        unit_res  <= '0;
        unit_flag <= 1'b0;
        if (!unit_mute) begin
            if (arith_enable) begin
                unit_res <= unit_eval(2'd0, alu_fun, alu_a, alu_b); unit_flag <= 1'b1;
            end else if (logic_enable) begin
                unit_res <= unit_eval(2'd1, alu_fun, alu_a, alu_b); unit_flag <= 1'b1;
            end else if (cmp_enable) begin
                unit_res <= unit_eval(2'd2, alu_fun, alu_a, alu_b); unit_flag <= 1'b1;
            end else if (shift_enable) begin
                unit_res <= unit_eval(2'd3, alu_fun, alu_a, alu_b); unit_flag <= 1'b1;
            end
        end
    end

    assign res_in   = force_flag ? 16'hBEEF : unit_res;
    assign res_flag = unit_flag | force_flag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] en_vec();
        return {arith_enable, logic_enable, cmp_enable, shift_enable};
    endfunction

    // Starts at a negedge in IDLE; ends at a negedge back in IDLE.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input string tag);
        logic [3:0] exp_en;
        exp_en = 4'b1000 >> op[3:2];
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b0;
        check({tag, "_idle_rdy"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_issue_en"}, 32'(en_vec()), 32'(exp_en));
        check({tag, "_issue_a"}, 32'(alu_a), 32'(a));
        check({tag, "_issue_b"}, 32'(alu_b), 32'(b));
        check({tag, "_issue_fun"}, 32'(alu_fun), 32'(op[1:0]));
        check({tag, "_issue_rdy"}, 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check({tag, "_wait_en"}, 32'(en_vec()), 32'd0);
        check({tag, "_wait_vld"}, 32'(rsp_valid), 32'd0);
        check({tag, "_wait_a"}, 32'(alu_a), 32'(a));
        @(negedge clk);
        check({tag, "_rsp_vld"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done_vld"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_rdy"}, 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdy",  32'(cmd_ready), 32'd1);
        check("rst_vld",  32'(rsp_valid), 32'd0);
        check("rst_en",   32'(en_vec()),  32'd0);
        check("rst_a",    32'(alu_a),     32'd0);
        check("rst_fun",  32'(alu_fun),   32'd0);
        check("rst_data", 32'(rsp_data),  32'd0);
        check("rst_err",  32'(rsp_err),   32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op(4'b1100, 16'h8001, 16'h0000, 16'h4000, "shr_a");
        run_op(4'b1101, 16'h0001, 16'h0000, 16'h0002, "shl_a");
        run_op(4'b1110, 16'h0000, 16'h0003, 16'h0001, "shr_b");
        run_op(4'b1111, 16'h0000, 16'h8000, 16'h0000, "shl_b_ovf");
        run_op(4'b0000, 16'h1234, 16'h0101, 16'h1335, "add");
        run_op(4'b0100, 16'hF0F0, 16'hFF00, 16'hF000, "and");
        run_op(4'b1001, 16'h0003, 16'h0005, 16'h0001, "lt");

        // timeout: no flag for 4 WAIT cycles
        unit_mute = 1'b1;
        cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 16'h0005; cmd_b = 16'h0003;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("to_issue_en", 32'(en_vec()), 32'b1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_wait_en",  32'(en_vec()),  32'd0);
            check("to_wait_vld", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        check("to_rsp_vld",  32'(rsp_valid), 32'd1);
        check("to_rsp_data", 32'(rsp_data),  32'd0);
        check("to_rsp_err",  32'(rsp_err),   32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("to_done_rdy", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b0;
        unit_mute = 1'b0;

        // spurious flag in IDLE
        force_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_flag_rdy", 32'(cmd_ready), 32'd1);
            check("idle_flag_vld", 32'(rsp_valid), 32'd0);
        end
        force_flag = 1'b0;
        @(negedge clk);

        // backpressure with a second command held pending
        cmd_valid = 1'b1; cmd_op = 4'b1101; cmd_a = 16'h0003; cmd_b = 16'h0000;
        @(negedge clk);
        cmd_op = 4'b0001; cmd_a = 16'h000A; cmd_b = 16'h0003;
        check("bp_issue_a", 32'(alu_a), 32'h0003);
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp_data", 32'(rsp_data), 32'h0006);
        force_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_vld",  32'(rsp_valid), 32'd1);
            check("bp_hold_data", 32'(rsp_data),  32'h0006);
            check("bp_hold_err",  32'(rsp_err),   32'd0);
            check("bp_hold_rdy",  32'(cmd_ready), 32'd0);
        end
        force_flag = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_rdy", 32'(cmd_ready), 32'd1);
        check("bp_idle_vld", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp2_issue_en", 32'(en_vec()), 32'b1000);
        check("bp2_issue_a",  32'(alu_a),    32'h000A);
        @(negedge clk);
        @(negedge clk);
        check("bp2_rsp_vld",  32'(rsp_valid), 32'd1);
        check("bp2_rsp_data", 32'(rsp_data),  32'h0007);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp2_done_rdy", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b0;

        // reset during ISSUE: enable drops without a clock edge
        cmd_valid = 1'b1; cmd_op = 4'b1000; cmd_a = 16'h0001; cmd_b = 16'h0001;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ri_issue_en", 32'(en_vec()), 32'b0010);
        #2 rst = 1'b0;
        #1;
        check("ri_en",  32'(en_vec()),  32'd0);
        check("ri_rdy", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // reset during WAIT
        unit_mute = 1'b1;
        cmd_valid = 1'b1; cmd_op = 4'b1100; cmd_a = 16'h0010; cmd_b = 16'h0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rw_wait_rdy", 32'(cmd_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("rw_en",   32'(en_vec()),  32'd0);
        check("rw_vld",  32'(rsp_valid), 32'd0);
        check("rw_rdy",  32'(cmd_ready), 32'd1);
        check("rw_a",    32'(alu_a),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        unit_mute = 1'b0;
        @(negedge clk);
        run_op(4'b1100, 16'h0010, 16'h0000, 16'h0008, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
